// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 round engine owning the state register, round counter, AddRoundKey and handshakes
module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int DP_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rnd,
    input  logic [127:0] round_key,
    output logic [127:0] dp_state,
    input  logic [127:0] dp_result,
    output logic         mc_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int CW = DP_LAT > 1 ? $clog2(DP_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ROUND, WAIT, DONE} st_t;

    st_t           st_q, st_d;
    logic [127:0]  state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last, load;

    assign last = rnd_q == 4'(NR);
    assign load = (st_q == ROUND && DP_LAT == 0) || (st_q == WAIT && cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        case (st_q)
            IDLE: if (in_valid) begin
                state_d = in_data ^ round_key;
                rnd_d   = 4'd1;
                st_d    = ROUND;
            end
            ROUND: if (DP_LAT != 0) begin
                cnt_d = CW'(DP_LAT - 1);
                st_d  = WAIT;
            end
            WAIT: cnt_d = cnt_q - 1'b1;
            DONE: if (out_ready) begin
                rnd_d = '0;
                st_d  = IDLE;
            end
            default: st_d = IDLE;
        endcase
        // the round result lands once the datapath latency has elapsed
        if (load) begin
            state_d = dp_result ^ round_key;
            rnd_d   = last ? rnd_q : rnd_q + 4'd1;
            st_d    = last ? DONE : ROUND;
        end
    end

    assign in_ready  = rst_n && st_q == IDLE;
    assign busy      = st_q != IDLE;
    assign mc_bypass = (st_q == ROUND || st_q == WAIT) && last;
    assign out_valid = st_q == DONE;
    assign rnd       = rnd_q;
    assign dp_state  = state_q;
    assign out_data  = state_q;

endmodule
